// File: rtl/pdm_decimator.sv
// pdm_decimator: boxcar decimator for a 1-bit PDM stream.
// It counts ones over a selectable window of 8/16/32/64 clocks.
// Each window total is scaled to a 0..31 level, and a full window raises sat.
// Pin map (8-in/8-out slot):
//   io_in  = {unused, wsel[1:0], hold, sync, pdm_in, reset_n, clk}
//   io_out = {locked, sat, valid, level[4:0]}
module pdm_decimator #(
   parameter logic [1:0] WSEL_RESET = 2'b10
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   logic       w_clk;
   logic       w_rst_n;
   logic       w_pdm;
   logic       w_sync;
   logic       w_hold;
   logic [1:0] w_wsel;
   logic       w_unused;

   assign w_clk    = io_in[0];
   assign w_rst_n  = io_in[1];
   assign w_pdm    = io_in[2];
   assign w_sync   = io_in[3];
   assign w_hold   = io_in[4];
   assign w_wsel   = io_in[6:5];
   assign w_unused = io_in[7];

   logic [5:0] r_pos;
   logic [6:0] r_acc;
   logic [1:0] r_wsel_q;
   logic [4:0] r_level;
   logic       r_valid;
   logic       r_sat;
   logic       r_locked;

   logic [5:0] w_wmax;      // index of the last sample in the active window
   logic [6:0] w_wsize;     // active window length W
   logic [6:0] w_n;         // window total, including the bit on this edge
   logic [8:0] w_scaled;    // unclamped level, wide enough for 8*4 and 64
   logic [4:0] w_level_next;
   logic       w_sat_next;
   logic       w_last;

   // Window geometry, window total, and scaling of that total to a 0..31 level
   always_comb begin
      w_wmax   = 6'd31;
      w_scaled = 9'd0;
      w_n      = r_acc + {6'd0, w_pdm};
      case (r_wsel_q)
         2'b00: begin
            w_wmax   = 6'd7;
            w_scaled = {w_n, 2'b00};
         end
         2'b01: begin
            w_wmax   = 6'd15;
            w_scaled = {1'b0, w_n, 1'b0};
         end
         2'b10: begin
            w_wmax   = 6'd31;
            w_scaled = {2'b00, w_n};
         end
         default: begin
            w_wmax   = 6'd63;
            w_scaled = {3'b000, w_n[6:1]};
         end
      endcase
      w_wsize      = {1'b0, w_wmax} + 7'd1;
      w_last       = (r_pos == w_wmax);
      w_sat_next   = (w_n == w_wsize);
      w_level_next = (w_scaled > 9'd31) ? 5'd31 : w_scaled[4:0];
   end

   // Count-and-dump state with priority sync > hold > normal sampling
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_pos    <= 6'd0;
         r_acc    <= 7'd0;
         r_wsel_q <= WSEL_RESET;
         r_level  <= 5'd0;
         r_valid  <= 1'b0;
         r_sat    <= 1'b0;
         r_locked <= 1'b0;
      end else if (w_sync) begin
         // Restart the window and drop lock; the last decoded level stays visible
         r_pos    <= 6'd0;
         r_acc    <= 7'd0;
         r_wsel_q <= w_wsel;
         r_valid  <= 1'b0;
         r_locked <= 1'b0;
      end else if (w_hold) begin
         r_valid  <= 1'b0;
      end else if (w_last) begin
         r_level  <= w_level_next;
         r_sat    <= w_sat_next;
         r_valid  <= 1'b1;
         r_locked <= 1'b1;
         r_pos    <= 6'd0;
         r_acc    <= 7'd0;
         r_wsel_q <= w_wsel;
      end else begin
         r_acc    <= w_n;
         r_pos    <= r_pos + 6'd1;
         r_valid  <= 1'b0;
      end
   end

   assign io_out = {r_locked, r_sat, r_valid, r_level};

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed testbench for pdm_decimator: each task drives one scenario and checks its outputs.
module tb_pdm_decimator;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       pdm   = 1'b0;
   logic       sync  = 1'b0;
   logic       hold  = 1'b0;
   logic [1:0] wsel  = 2'b10;
   logic [7:0] io_in;
   logic [7:0] io_out;

   int checks   = 0;
   int failures = 0;

   assign io_in = {1'b0, wsel, hold, sync, pdm, rst_n, clk};

   pdm_decimator #(.WSEL_RESET(2'b10)) dut (
      .io_in (io_in),
      .io_out(io_out)
   );

   wire [4:0] level  = io_out[4:0];
   wire       valid  = io_out[5];
   wire       sat    = io_out[6];
   wire       locked = io_out[7];

   always #5 clk = ~clk;

   // One clock edge with the given pdm bit; returns 1 time unit after the edge
   task automatic step(input logic b);
      pdm = b;
      @(posedge clk);
      #1;
   endtask

   // Reset with the given wsel present; returns just after release
   task automatic do_reset(input logic [1:0] ws);
      sync  = 1'b0;
      hold  = 1'b0;
      wsel  = ws;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #3;
      checks++;
      if (io_out !== 8'h00) begin
         failures++;
         $display("FAIL reset_state got=%h exp=00", io_out);
      end
      do_reset(2'b10);
      checks++;
      if (io_out !== 8'h00) begin
         failures++;
         $display("FAIL reset_release got=%h exp=00", io_out);
      end
   endtask

   task automatic test_all_ones;
      for (int e = 1; e <= 31; e++) begin
         step(1'b1);
         checks++;
         if (valid !== 1'b0) begin
            failures++;
            $display("FAIL ones_early_valid edge=%0d got=%b exp=0", e, valid);
         end
      end
      step(1'b1);
      checks++;
      if (io_out !== {1'b1, 1'b1, 1'b1, 5'd31}) begin
         failures++;
         $display("FAIL ones_w32 got=%h exp=%h", io_out, {1'b1, 1'b1, 1'b1, 5'd31});
      end
      step(1'b1);
      checks++;
      if (valid !== 1'b0 || level !== 5'd31 || locked !== 1'b1) begin
         failures++;
         $display("FAIL ones_after_valid got v=%b l=%0d k=%b exp v=0 l=31 k=1", valid, level, locked);
      end
      for (int e = 2; e <= 31; e++) step(1'b1);
      step(1'b1);
      checks++;
      if (valid !== 1'b1 || level !== 5'd31 || sat !== 1'b1) begin
         failures++;
         $display("FAIL ones_edge64 got v=%b l=%0d s=%b exp v=1 l=31 s=1", valid, level, sat);
      end
      $display("txn all_ones level=%0d sat=%b", level, sat);
   endtask

   task automatic test_patterns;
      // 1000 repeating: 8 ones per 32
      for (int i = 0; i < 32; i++) step((i % 4) == 0);
      checks++;
      if (valid !== 1'b1 || level !== 5'd8 || sat !== 1'b0) begin
         failures++;
         $display("FAIL pat1000 got v=%b l=%0d s=%b exp v=1 l=8 s=0", valid, level, sat);
      end
      $display("txn pattern_1000 level=%0d", level);
      // 1101 repeating: 24 ones per 32
      for (int i = 0; i < 32; i++) step((i % 4) != 2);
      checks++;
      if (valid !== 1'b1 || level !== 5'd24 || sat !== 1'b0) begin
         failures++;
         $display("FAIL pat1101 got v=%b l=%0d s=%b exp v=1 l=24 s=0", valid, level, sat);
      end
      $display("txn pattern_1101 level=%0d", level);
   endtask

   task automatic test_w8;
      do_reset(2'b00);
      // First window is still 32 clocks
      for (int i = 0; i < 31; i++) step((i % 2) == 0);
      checks++;
      if (valid !== 1'b0) begin
         failures++;
         $display("FAIL w8_first_early got=%b exp=0", valid);
      end
      step(1'b0);
      checks++;
      if (valid !== 1'b1 || level !== 5'd16) begin
         failures++;
         $display("FAIL w8_first_window got v=%b l=%0d exp v=1 l=16", valid, level);
      end
      for (int i = 0; i < 8; i++) step((i % 2) == 0);
      checks++;
      if (valid !== 1'b1 || level !== 5'd16 || sat !== 1'b0) begin
         failures++;
         $display("FAIL w8_alt got v=%b l=%0d s=%b exp v=1 l=16 s=0", valid, level, sat);
      end
      for (int i = 0; i < 8; i++) step(i != 7);
      checks++;
      if (valid !== 1'b1 || level !== 5'd28 || sat !== 1'b0) begin
         failures++;
         $display("FAIL w8_seven got v=%b l=%0d s=%b exp v=1 l=28 s=0", valid, level, sat);
      end
      $display("txn w8 level=%0d", level);
   endtask

   task automatic test_w64;
      do_reset(2'b11);
      for (int i = 0; i < 32; i++) step(1'b0);
      checks++;
      if (valid !== 1'b1 || level !== 5'd0) begin
         failures++;
         $display("FAIL w64_first got v=%b l=%0d exp v=1 l=0", valid, level);
      end
      for (int i = 0; i < 63; i++) step((i % 2) == 0);
      checks++;
      if (valid !== 1'b0) begin
         failures++;
         $display("FAIL w64_early got=%b exp=0", valid);
      end
      step(1'b0);
      checks++;
      if (valid !== 1'b1 || level !== 5'd16 || sat !== 1'b0) begin
         failures++;
         $display("FAIL w64_alt got v=%b l=%0d s=%b exp v=1 l=16 s=0", valid, level, sat);
      end
      for (int i = 0; i < 64; i++) step(1'b1);
      checks++;
      if (valid !== 1'b1 || level !== 5'd31 || sat !== 1'b1) begin
         failures++;
         $display("FAIL w64_ones got v=%b l=%0d s=%b exp v=1 l=31 s=1", valid, level, sat);
      end
      for (int i = 0; i < 64; i++) step(i != 63);
      checks++;
      if (valid !== 1'b1 || level !== 5'd31 || sat !== 1'b0) begin
         failures++;
         $display("FAIL w64_63ones got v=%b l=%0d s=%b exp v=1 l=31 s=0", valid, level, sat);
      end
      $display("txn w64 level=%0d sat=%b", level, sat);
   endtask

   task automatic test_hold_sync;
      do_reset(2'b10);
      for (int i = 0; i < 32; i++) step(1'b1);
      // Next window: 10 ones, 5 held clocks, then 22 zeros -> n=10
      for (int i = 0; i < 10; i++) step(1'b1);
      hold = 1'b1;
      for (int i = 0; i < 5; i++) step(1'b1);
      hold = 1'b0;
      for (int i = 0; i < 21; i++) step(1'b0);
      checks++;
      if (valid !== 1'b0 || level !== 5'd31) begin
         failures++;
         $display("FAIL hold_early got v=%b l=%0d exp v=0 l=31", valid, level);
      end
      step(1'b0);
      checks++;
      if (valid !== 1'b1 || level !== 5'd10 || sat !== 1'b0) begin
         failures++;
         $display("FAIL hold_window got v=%b l=%0d s=%b exp v=1 l=10 s=0", valid, level, sat);
      end
      $display("txn hold level=%0d", level);
      sync = 1'b1;
      step(1'b1);
      sync = 1'b0;
      checks++;
      if (valid !== 1'b0 || locked !== 1'b0 || level !== 5'd10) begin
         failures++;
         $display("FAIL sync_edge got v=%b k=%b l=%0d exp v=0 k=0 l=10", valid, locked, level);
      end
      for (int i = 0; i < 31; i++) step(1'b1);
      checks++;
      if (valid !== 1'b0 || locked !== 1'b0 || level !== 5'd10) begin
         failures++;
         $display("FAIL sync_wait got v=%b k=%b l=%0d exp v=0 k=0 l=10", valid, locked, level);
      end
      step(1'b1);
      checks++;
      if (valid !== 1'b1 || locked !== 1'b1 || level !== 5'd31) begin
         failures++;
         $display("FAIL sync_window got v=%b k=%b l=%0d exp v=1 k=1 l=31", valid, locked, level);
      end
      $display("txn sync level=%0d", level);
   endtask

   task automatic test_sync_at_boundary;
      for (int i = 0; i < 31; i++) step(1'b0);
      sync = 1'b1;
      step(1'b0);
      sync = 1'b0;
      checks++;
      if (valid !== 1'b0 || level !== 5'd31 || sat !== 1'b1 || locked !== 1'b0) begin
         failures++;
         $display("FAIL sync_boundary got v=%b l=%0d s=%b k=%b exp v=0 l=31 s=1 k=0", valid, level, sat, locked);
      end
      $display("txn sync_boundary level=%0d", level);
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 32; i++) step(1'b1);
      for (int i = 0; i < 20; i++) step(1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (io_out !== 8'h00) begin
         failures++;
         $display("FAIL reset_mid got=%h exp=00", io_out);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int e = 1; e <= 31; e++) begin
         step(1'b1);
         checks++;
         if (valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_early edge=%0d got=%b exp=0", e, valid);
         end
      end
      step(1'b1);
      checks++;
      if (io_out !== {1'b1, 1'b1, 1'b1, 5'd31}) begin
         failures++;
         $display("FAIL reset_mid_window got=%h exp=%h", io_out, {1'b1, 1'b1, 1'b1, 5'd31});
      end
      $display("txn reset_mid level=%0d", level);
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_patterns();
      test_w8();
      test_w64();
      test_hold_sync();
      test_sync_at_boundary();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
